bin_to_bcd_double_dabble: RTL and testbench
===========================================

# bin_to_bcd_double_dabble

Iterative binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm, one bit per clock. It is the display-side counterpart of the team's BCD-to-binary input converter. The calculator core produces binary results, and this block turns them into packed BCD digits for the seven-segment/display path. It uses an enable/valid handshake matching the converter on the input side.

## Interface
- WIDTH, 8, binary input width in bits (≥ 2).
- DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH − 1 (elaboration-time check; 3 for WIDTH=8).
- clk  input  1  single system clock, all logic on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- i_binary  input  WIDTH  unsigned value to convert, sampled only on accept.
- enable  input  1  start request, sampled each edge.
- o_bcd  output  4·DIGITS  packed BCD result, digit 0 (ones) in [3:0].
- o_busy  output  1  high while a conversion is in progress.
- out_dataV  output  1  one-cycle pulse: o_bcd holds a new result.

## Operation
- States: IDLE, CONVERT.
- IDLE: when enable=1, the edge performs these actions:
  - latch i_binary into the shift register;
  - clear the BCD scratch register;
  - clear the iteration counter to 0;
  - set o_busy=1 and go to CONVERT.
- CONVERT: each edge performs one iteration:
  - every scratch digit ≥ 5 gets +3;
  - then {scratch, shift} shifts left by 1 as one concatenated register;
  - the counter increments.
- The final iteration is counter = WIDTH−1. On that edge:
  - o_bcd loads the post-shift scratch value;
  - out_dataV is set to 1 and o_busy to 0;
  - the state returns to IDLE.
- Arithmetic rules:
  - Scratch is 4·DIGITS bits; bits shifted out of the top digit are discarded (impossible when the DIGITS rule holds).
  - Every output digit is always in 0–9.
- enable while o_busy=1 is ignored (no queueing) and does not disturb the conversion.
- i_binary changes after accept have no effect.
- o_bcd holds its last result until the next completion; it is not cleared on a new accept.
- Back-to-back: enable high in the cycle where out_dataV=1 (state IDLE) is accepted. The next result follows WIDTH+1 edges later.

## Timing
- Reset (rst_n=0, asynchronous) drives these values:
  - state = IDLE;
  - o_bcd = 0, o_busy = 0, out_dataV = 0;
  - scratch, shift register and counter = 0.
- Reset during CONVERT aborts the conversion. No out_dataV is produced, and o_bcd is 0 after reset.
- Latency: enable is sampled at edge E0. out_dataV is visible after edge E_WIDTH (E8 at default) and falls after E_WIDTH+1.
- Throughput: one conversion per WIDTH+1 cycles at best.
- o_busy is high from after E0 through E_WIDTH−1 and low after E_WIDTH.
- out_dataV is never high for two consecutive cycles except on back-to-back completions, which cannot occur closer than WIDTH+1 apart.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package (calc_pkg): state encoding constants (IDLE, CONVERT), BCD_DIGIT_W = 4, and the digit correction threshold/addend constants (5, 3).
- Sub-module bcd_add3: combinational 4-bit digit correction (in ≥ 5 → in+3, else in). The top level instantiates it DIGITS times in a generate loop.
- Counter width is clog2(WIDTH).

## Test plan
- Reset release, then i_binary=0 with a one-cycle enable → o_busy high for 8 cycles; out_dataV pulses once after E8 with o_bcd=12'h000.
- i_binary=255 → o_bcd=12'h255. i_binary=99 → 12'h099. i_binary=100 → 12'h100. i_binary=9 → 12'h009, and i_binary=10 → 12'h010.
- Exhaustive sweep 0–255, checked against a reference model (hundreds, tens, ones):
  - exactly one out_dataV per request;
  - all digits ≤ 9.
- Back-to-back: request 37, then enable=1 again in the out_dataV cycle with 200 → results 12'h037 then 12'h200, second pulse exactly 9 edges after the first.
- Enable pulses plus i_binary changes mid-conversion (request 123, then 45 applied at E3) → result 12'h123 only; no extra out_dataV.
- rst_n asserted at E4 of a conversion of 250 → all outputs 0 immediately (asynchronously); no out_dataV. After release, a new request for 250 → 12'h250.

Source files
------------

// File: rtl/bin_to_bcd_double_dabble_pkg.sv
// Shared constants for the binary-to-BCD display converter.
// Contents: FSM state encoding, BCD digit width, the digit correction threshold
// and addend, and an elaboration helper that checks DIGITS is wide enough for WIDTH.
package bin_to_bcd_double_dabble_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESHOLD = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] ADD3_ADDEND    = 4'd3;

  typedef enum logic {
    StIdle    = 1'b0,
    StConvert = 1'b1
  } state_e;

  // True when 10^digits > 2^width - 1, i.e. every WIDTH-bit value fits.
  function automatic bit digits_cover_width(input int unsigned width,
                                            input int unsigned digits);
    longint unsigned pow10;
    longint unsigned max_bin;
    pow10 = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      pow10 = pow10 * 10;
    end
    max_bin = (64'd1 << width) - 64'd1;
    return pow10 > max_bin;
  endfunction

endpackage

// File: rtl/bin_to_bcd_double_dabble_if.sv
// Handshake bundle between the calculator core and the binary-to-BCD converter.
// Signals:
//   i_binary  - unsigned value to convert (sampled on accept)
//   enable    - start request
//   o_bcd     - packed BCD result, ones digit in [3:0]
//   o_busy    - conversion in progress
//   out_dataV - one-cycle pulse when o_bcd holds a new result
// Modports: master drives the request, slave is the converter.
interface bin_to_bcd_double_dabble_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) ();

  logic [WIDTH-1:0]    i_binary;
  logic                enable;
  logic [4*DIGITS-1:0] o_bcd;
  logic                o_busy;
  logic                out_dataV;

  modport master (
    output i_binary,
    output enable,
    input  o_bcd,
    input  o_busy,
    input  out_dataV
  );

  modport slave (
    input  i_binary,
    input  enable,
    output o_bcd,
    output o_busy,
    output out_dataV
  );

endinterface

// File: rtl/bin_to_bcd_double_dabble_bcd_add3.sv
// Combinational double-dabble digit correction: a digit of 5 or more gets +3 so
// that the following left shift carries correctly into the next decimal digit.
// Ports:
//   digit_i - 4-bit BCD scratch digit before correction
//   digit_o - corrected digit
module bin_to_bcd_double_dabble_bcd_add3
  import bin_to_bcd_double_dabble_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= ADD3_THRESHOLD) begin
      digit_o = digit_i + ADD3_ADDEND;
    end
  end

endmodule

// File: rtl/bin_to_bcd_double_dabble.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - slave side of the converter handshake (see the interface file)
// A request accepted in idle takes WIDTH clocks; the result appears in o_bcd with
// a one-cycle out_dataV pulse. Requests while busy are ignored.
module bin_to_bcd_double_dabble
  import bin_to_bcd_double_dabble_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  bin_to_bcd_double_dabble_if.slave   bus
);

  localparam int unsigned ScrW = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("bin_to_bcd_double_dabble: WIDTH must be at least 2");
  end
  if (!digits_cover_width(WIDTH, DIGITS)) begin : g_bad_digits
    $error("bin_to_bcd_double_dabble: DIGITS too small for WIDTH");
  end

  state_e          state_q;
  logic [WIDTH-1:0] shift_q;
  logic [ScrW-1:0]  scratch_q;
  logic [CntW-1:0]  cnt_q;
  logic [ScrW-1:0]  bcd_q;
  logic             busy_q;
  logic             dv_q;

  logic [ScrW-1:0]  scratch_corr;
  logic [ScrW-1:0]  scratch_shl;
  logic [WIDTH-1:0] shift_shl;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bin_to_bcd_double_dabble_bcd_add3 u_add3 (
      .digit_i (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (scratch_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // {scratch, shift} shifts as one register; the top scratch bit is dropped,
  // which cannot lose information while DIGITS covers WIDTH.
  always_comb begin
    scratch_shl = {scratch_corr[ScrW-2:0], shift_q[WIDTH-1]};
    shift_shl   = {shift_q[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      busy_q    <= 1'b0;
      dv_q      <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.enable) begin
            shift_q   <= bus.i_binary;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= StConvert;
          end
        end
        StConvert: begin
          scratch_q <= scratch_shl;
          shift_q   <= shift_shl;
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            bcd_q   <= scratch_shl;
            dv_q    <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign bus.o_bcd     = bcd_q;
  assign bus.o_busy    = busy_q;
  assign bus.out_dataV = dv_q;

endmodule

// File: tb/tb_bin_to_bcd_double_dabble.sv
// Self-checking bench for bin_to_bcd_double_dabble: directed values, exhaustive
// sweep, back-to-back requests, mid-conversion disturbance and async reset abort.
module tb_bin_to_bcd_double_dabble;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DIGITS = 3;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bin_to_bcd_double_dabble_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus_if ();

  bin_to_bcd_double_dabble #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_asserts = 0;
  int n_fail    = 0;
  int pulses    = 0;
  int pops      = 0;
  logic [4*DIGITS-1:0] exp_q[$];

  // Independent count of every result pulse seen on the output.
  always @(negedge clk) begin
    if (bus_if.out_dataV === 1'b1) pulses++;
  end

  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge E0.
  task automatic start(input int v);
    bus_if.i_binary = WIDTH'(v);
    bus_if.enable   = 1'b1;
    exp_q.push_back(ref_bcd(v));
    @(negedge clk);
    bus_if.enable   = 1'b0;
  endtask

  // Called at the negedge after E_WIDTH.
  task automatic finish_check(input string tag);
    logic [4*DIGITS-1:0] exp;
    check({tag, "_dv"}, 32'(bus_if.out_dataV), 32'd1);
    check({tag, "_busy_low"}, 32'(bus_if.o_busy), 32'd0);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      pops++;
      check({tag, "_bcd"}, 32'(bus_if.o_bcd), 32'(exp));
      for (int d = 0; d < DIGITS; d++) begin
        check({tag, "_digit_le9"}, 32'(bus_if.o_bcd[d*4 +: 4] <= 4'd9), 32'd1);
      end
    end
  endtask

  task automatic conv(input int v, input string tag);
    start(v);
    for (int i = 0; i < WIDTH; i++) begin
      check({tag, "_busy"}, 32'(bus_if.o_busy), 32'd1);
      check({tag, "_no_dv"}, 32'(bus_if.out_dataV), 32'd0);
      @(negedge clk);
    end
    finish_check(tag);
  endtask

  initial begin
    int dir [5];
    dir = '{255, 99, 100, 9, 10};

    rst_n           = 1'b0;
    bus_if.enable   = 1'b0;
    bus_if.i_binary = '0;
    repeat (3) @(negedge clk);
    check("rst_bcd", 32'(bus_if.o_bcd), 32'd0);
    check("rst_busy", 32'(bus_if.o_busy), 32'd0);
    check("rst_dv", 32'(bus_if.out_dataV), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    conv(0, "zero");
    @(negedge clk);
    check("zero_single_pulse", 32'(bus_if.out_dataV), 32'd0);

    foreach (dir[k]) begin
      conv(dir[k], "directed");
      @(negedge clk);
      check("directed_single_pulse", 32'(bus_if.out_dataV), 32'd0);
    end

    // Sweep runs back-to-back: each request lands in the previous pulse cycle.
    for (int v = 0; v < 256; v++) begin
      conv(v, "sweep");
    end
    @(negedge clk);
    check("sweep_end_no_dv", 32'(bus_if.out_dataV), 32'd0);

    // Second pulse is exactly WIDTH+1 edges after the first.
    conv(37, "b2b_first");
    conv(200, "b2b_second");
    @(negedge clk);
    check("b2b_end_no_dv", 32'(bus_if.out_dataV), 32'd0);

    // 123 accepted; enable with 45 sampled at E3 must be ignored.
    start(123);
    for (int i = 1; i <= WIDTH; i++) begin
      check("mid_busy", 32'(bus_if.o_busy), 32'd1);
      check("mid_no_dv", 32'(bus_if.out_dataV), 32'd0);
      if (i == 3) begin
        bus_if.i_binary = 8'd45;
        bus_if.enable   = 1'b1;
      end else begin
        bus_if.enable   = 1'b0;
      end
      @(negedge clk);
    end
    bus_if.enable = 1'b0;
    finish_check("mid");
    repeat (12) begin
      @(negedge clk);
      check("mid_no_extra_dv", 32'(bus_if.out_dataV), 32'd0);
    end

    // Abort a conversion of 250 with reset at E4.
    start(250);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_bcd", 32'(bus_if.o_bcd), 32'd0);
    check("abort_busy", 32'(bus_if.o_busy), 32'd0);
    check("abort_dv", 32'(bus_if.out_dataV), 32'd0);
    exp_q.delete();
    repeat (WIDTH + 2) begin
      @(negedge clk);
      check("abort_held_no_dv", 32'(bus_if.out_dataV), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_after_release_no_dv", 32'(bus_if.out_dataV), 32'd0);
    conv(250, "post_rst");
    @(negedge clk);
    check("post_rst_single_pulse", 32'(bus_if.out_dataV), 32'd0);
    repeat (2) @(negedge clk);

    check("pulse_count", 32'(pulses), 32'(pops));
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
